dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache controller. It sits between the CPU load/store path and the block-organised data memory, and acts as the initiator on the memory's block read/write port. It turns single-word CPU accesses into whole-line refills and write-backs. One line equals one memory block.

---
 rtl/dcache_ctrl_if.sv | 31 +++
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU load/store and memory block-port signals of the data cache controller.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 512
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;

    // Cache controller side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, cpu_busy, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    // CPU and memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, cpu_busy, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cpu_req; request fields latched on acceptance
// COMPARE   | tag lookup; a hit completes the access (cpu_ready pulse)
// WB        | one-cycle block write of the dirty victim line
// FILL_REQ  | one-cycle block read request for the requested line
// FILL_WAIT | memory data arrives; line installed clean, back to COMPARE
module dcache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 512,
    parameter int LINES  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_ctrl_if.slave  bus
);
    localparam int OB  = $clog2(LINE_W / 8);
    localparam int IB  = $clog2(LINES);
    localparam int TW  = ADDR_W - OB - IB;
    localparam int WSB = OB - 2;

    typedef enum logic [2:0] {IDLE, COMPARE, WB, FILL_REQ, FILL_WAIT} state_t;

    state_t state, state_nx;

    // Latched request; the byte-within-word bits are never needed.
    logic [ADDR_W-3:0] req_a;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;

    logic [LINE_W-1:0] data_arr [LINES];
    logic [TW-1:0]     tag_arr  [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [DATA_W-1:0] rdata_q;

    logic [TW-1:0]     req_tag;
    logic [IB-1:0]     req_idx;
    logic [WSB-1:0]    req_word;
    logic [WSB-1:0]    wsel;
    logic [LINE_W-1:0] line_q;
    logic [DATA_W-1:0] word_rd;
    logic              hit;
    logic              ready_c;
    logic              rd_c;
    logic              wr_c;
    logic [ADDR_W-1:0] maddr_c;
    logic [LINE_W-1:0] mwdata_c;

    assign req_tag  = req_a[ADDR_W-3 -: TW];
    assign req_idx  = req_a[OB+IB-3 -: IB];
    assign req_word = req_a[WSB-1:0];
    // Big-endian packing: word 0 sits in the top bits, so the lsb-based slot is the complement.
    assign wsel     = ~req_word;
    assign line_q   = data_arr[req_idx];
    assign word_rd  = line_q[DATA_W*wsel +: DATA_W];
    assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);

    // Next state plus Moore memory strobes; cpu_ready is the COMPARE-hit cycle.
    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        rd_c     = 1'b0;
        wr_c     = 1'b0;
        maddr_c  = '0;
        mwdata_c = '0;
        case (state)
            IDLE: begin
                if (bus.cpu_req) state_nx = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    ready_c  = 1'b1;
                    state_nx = IDLE;
                end else if (valid[req_idx] && dirty[req_idx]) begin
                    state_nx = WB;
                end else begin
                    state_nx = FILL_REQ;
                end
            end
            WB: begin
                wr_c     = 1'b1;
                maddr_c  = {tag_arr[req_idx], req_idx, {OB{1'b0}}};
                mwdata_c = line_q;
                state_nx = FILL_REQ;
            end
            FILL_REQ: begin
                rd_c     = 1'b1;
                maddr_c  = {req_tag, req_idx, {OB{1'b0}}};
                state_nx = FILL_WAIT;
            end
            FILL_WAIT: begin
                state_nx = COMPARE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, request latch, line status bits and the held load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_a     <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            valid     <= '0;
            dirty     <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.cpu_req) begin
                req_a     <= bus.cpu_addr[ADDR_W-1:2];
                req_we    <= bus.cpu_we;
                req_wdata <= bus.cpu_wdata;
            end
            if (state == COMPARE && hit) begin
                if (req_we) dirty[req_idx] <= 1'b1;
                else        rdata_q        <= word_rd;
            end
            if (state == FILL_WAIT) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end
        end
    end

    // Line data and tags; writes only happen in FILL_WAIT or a store hit, never while in reset.
    always_ff @(posedge clk) begin
        if (state == FILL_WAIT) begin
            data_arr[req_idx] <= bus.mem_rdata;
            tag_arr[req_idx]  <= req_tag;
        end else if (state == COMPARE && hit && req_we) begin
            data_arr[req_idx][DATA_W*wsel +: DATA_W] <= req_wdata;
        end
    end

    assign bus.cpu_ready = ready_c;
    assign bus.cpu_rdata = (state == COMPARE && hit && !req_we) ? word_rd : rdata_q;
    assign bus.cpu_busy  = (state != IDLE);
    assign bus.mem_rd    = rd_c;
    assign bus.mem_wr    = wr_c;
    assign bus.mem_addr  = maddr_c;
    assign bus.mem_wdata = mwdata_c;
endmodule
